ssit: RTL and testbench
=======================

// Module: ssit
// PURPOSE
//  Store Set ID Table for store-set memory dependence prediction; PC-indexed producer side of the LFST.
//  Rename presents up to 4 fetched load/store PCs per cycle; ssit returns each one's SSID + valid,
//  which feed LFST ssidN_in/validN_in the next cycle. On a reported load/store order violation,
//  ssit allocates or merges store sets via a req/ack FSM. Optional periodic bulk clear.
// PARAMETERS
//  IDX_W        10     SSIT index width; ENTRIES = 1<<IDX_W; index = pc[IDX_W+1:2]
//  SSID_W       7      SSID width; must match LFST SSID space (128 sets)
//  CLEAR_PERIOD 65536  cycles between bulk clears (only with SSIT_PERIODIC_CLEAR_EN); >= 2
// PORTS
//  clock           in   1       clock, all state on posedge
//  reset_n         in   1       synchronous active-low reset
//  pc0_in..pc3_in  in   64      fetched instruction PCs, slot 0 oldest
//  valid0_in..3    in   1       slot N holds a load or store
//  ssid0_out..3    out  SSID_W  SSID of slot N, registered
//  ssid_v0_out..3  out  1       slot N has a valid SSIT entry (and validN_in was set)
//  viol_req_in     in   1       violation report; held with operands until viol_ack_out
//  viol_ld_pc_in   in   64      PC of violating load
//  viol_st_pc_in   in   64      PC of store it depended on
//  viol_ack_out    out  1       one-cycle pulse: violation written to table
//  busy_out        out  1       FSM not IDLE
// BEHAVIOUR
//  Storage: ssid_f[ENTRIES] (SSID_W each), ssid_v_f[ENTRIES] valid bits, alloc_f SSID counter.
//  Reset (reset_n=0 at posedge): all valid bits 0, alloc_f=0, FSM=IDLE, ssidN_out=0, ssid_vN_out=0,
//   viol_ack_out=0, busy_out=0; period counter=0. ssid_f contents not reset. Reset mid-op aborts, no ack.
//  Lookup: 1-cycle latency. At posedge, ssidN_out <= ssid_f[idx(pcN_in)],
//   ssid_vN_out <= ssid_v_f[idx(pcN_in)] & validN_in. Reads see pre-write array state (no bypass);
//   a lookup in the same cycle as a WR or CLR write returns old contents. Lookups never stall.
//  FSM states: IDLE, RD, WR, CLR.
//   IDLE: viol_req_in=1 -> RD, latch ld/st indices. Clear due (macro) has priority over a new req -> CLR.
//   RD:  capture entries: lv=ssid_v_f[ld], sv=ssid_v_f[st], ls=ssid_f[ld], ss=ssid_f[st]. -> WR.
//   WR:  apply merge; viol_ack_out=1 this cycle; -> IDLE. Requester drops req after ack.
//        Same req seen again in IDLE the cycle after ack starts a new violation (requester's job).
//   CLR: clear all ssid_v_f in one cycle; -> IDLE. Pending viol_req_in waits (no ack) until IDLE.
//  Merge rules (store-set assignment):
//   !lv & !sv: both entries <= alloc_f, valid; alloc_f <= alloc_f+1, wraps 2^SSID_W-1 -> 0.
//    lv & !sv: st entry <= ls.     !lv & sv: ld entry <= ss.
//    lv &  sv: both <= min(ls,ss) (unsigned); equal -> no change.
//   ld idx == st idx (alias): single entry written; allocate only if entry invalid.
//  No flush input: SSIT is predictive state and persists across pipeline flushes.
//  busy_out = (state != IDLE).
// CONFIGURATION
//  SSIT_PERIODIC_CLEAR_EN defined: period counter counts 0..CLEAR_PERIOD-1 every cycle, wraps; at
//   wrap, clear-due flag set; taken on next IDLE cycle (CLR), flag cleared on entering CLR.
//   Due while in RD/WR: current violation completes first, then CLR. alloc_f not reset by CLR.
//  Not defined: no counter, no CLR state; entries invalidated only by reset.
// TESTING
//  Reset, lookup any 4 PCs with valid=1 -> next cycle ssid_vN_out=0, ssidN_out=0.
//  Viol ld=0x1000 st=0x2000 on empty table -> ack 2 cycles after req; lookup both -> SSID 0, valid;
//   second disjoint viol (0x3000/0x4000) -> SSID 1.
//  Entry 0x1000=SSID 5, 0x2000=SSID 3 valid; viol ld=0x1000 st=0x2000 -> both read 3.
//  Only load 0x1000=SSID 5 valid; viol st=0x5000 -> 0x5000 reads 5, alloc_f unchanged.
//  Alloc wrap: 128 disjoint new-set violations -> 129th allocates SSID 0 again.
//  Macro on, CLEAR_PERIOD=16: valid entry reads invalid after clear; req held during CLR acked after.

Source files
------------

// File: rtl/ssit.sv
// ---------------------------------------------------------------------------
// ssit -- Store Set ID Table (producer side of store-set dependence predictor)
//
// Purpose:
//   PC-indexed table of store-set IDs. Up to four load/store PCs are looked up
//   per cycle with one cycle of latency. Reported load/store ordering
//   violations are folded into the table by a small IDLE/RD/WR(/CLR) FSM that
//   allocates new store sets or merges existing ones.
//
// Ports:
//   clock, reset_n                 clock; synchronous active-low reset
//   pc0_in..pc3_in, valid0_in..3   lookup PCs (slot 0 oldest) and slot valids
//   ssid0_out..3, ssid_v0_out..3   registered lookup results
//   viol_req_in, viol_ld_pc_in,
//   viol_st_pc_in                  violation report, held until viol_ack_out
//   viol_ack_out                   one-cycle pulse while the merge is written
//   busy_out                       FSM not in IDLE
//
// Configuration:
//   SSIT_PERIODIC_CLEAR_EN  when defined, all valid bits are cleared once every
//                           CLEAR_PERIOD cycles through the CLR state.
// ---------------------------------------------------------------------------
module ssit #(
  parameter int IDX_W        = 10,
  parameter int SSID_W       = 7,
  parameter int CLEAR_PERIOD = 65536
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [63:0]       pc0_in,
  input  logic [63:0]       pc1_in,
  input  logic [63:0]       pc2_in,
  input  logic [63:0]       pc3_in,
  input  logic              valid0_in,
  input  logic              valid1_in,
  input  logic              valid2_in,
  input  logic              valid3_in,
  output logic [SSID_W-1:0] ssid0_out,
  output logic [SSID_W-1:0] ssid1_out,
  output logic [SSID_W-1:0] ssid2_out,
  output logic [SSID_W-1:0] ssid3_out,
  output logic              ssid_v0_out,
  output logic              ssid_v1_out,
  output logic              ssid_v2_out,
  output logic              ssid_v3_out,
  input  logic              viol_req_in,
  input  logic [63:0]       viol_ld_pc_in,
  input  logic [63:0]       viol_st_pc_in,
  output logic              viol_ack_out,
  output logic              busy_out
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [SSID_W-1:0] ssid_t;

`ifdef SSIT_PERIODIC_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

  // Only the word-index bits of each PC select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc0_in[63:IDX_W+2], pc0_in[1:0], pc1_in[63:IDX_W+2], pc1_in[1:0],
                            pc2_in[63:IDX_W+2], pc2_in[1:0], pc3_in[63:IDX_W+2], pc3_in[1:0],
                            viol_ld_pc_in[63:IDX_W+2], viol_ld_pc_in[1:0],
                            viol_st_pc_in[63:IDX_W+2], viol_st_pc_in[1:0]};

  // ---------------- storage ----------------
  ssid_t               ssid_q [ENTRIES];
  logic [ENTRIES-1:0]  ssid_v_q, ssid_v_d;
  ssid_t               alloc_q, alloc_d;

  // ---------------- lookup path ----------------
  idx_t  lk_idx   [4];
  logic  lk_valid [4];
  ssid_t lk_ssid_q [4], lk_ssid_d [4];
  logic  lk_v_q    [4], lk_v_d    [4];

  assign lk_idx[0] = pc0_in[IDX_W+1:2];
  assign lk_idx[1] = pc1_in[IDX_W+1:2];
  assign lk_idx[2] = pc2_in[IDX_W+1:2];
  assign lk_idx[3] = pc3_in[IDX_W+1:2];
  assign lk_valid[0] = valid0_in;
  assign lk_valid[1] = valid1_in;
  assign lk_valid[2] = valid2_in;
  assign lk_valid[3] = valid3_in;

  // Reads use the registered array state, so a same-cycle write is not bypassed.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lk_ssid_d[i] = ssid_q[lk_idx[i]];
      lk_v_d[i]    = ssid_v_q[lk_idx[i]] & lk_valid[i];
    end
  end

  assign ssid0_out   = lk_ssid_q[0];
  assign ssid1_out   = lk_ssid_q[1];
  assign ssid2_out   = lk_ssid_q[2];
  assign ssid3_out   = lk_ssid_q[3];
  assign ssid_v0_out = lk_v_q[0];
  assign ssid_v1_out = lk_v_q[1];
  assign ssid_v2_out = lk_v_q[2];
  assign ssid_v3_out = lk_v_q[3];

  // ---------------- violation FSM ----------------
  state_t state_q, state_d;
  idx_t   ld_idx_q, ld_idx_d, st_idx_q, st_idx_d;
  logic   lv_q, lv_d, sv_q, sv_d;
  ssid_t  ls_q, ls_d, ss_q, ss_d;
  logic   wr_ld_en, wr_st_en;
  ssid_t  wr_ld_val, wr_st_val, merge_min;
  logic   clr_take;

`ifdef SSIT_PERIODIC_CLEAR_EN
  localparam int CNT_W = $clog2(CLEAR_PERIOD);
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_due_q, clr_due_d;
  logic             clr_wrap;

  always_comb begin
    clr_wrap  = (clr_cnt_q == CNT_W'(CLEAR_PERIOD - 1));
    clr_cnt_d = clr_wrap ? '0 : clr_cnt_q + 1'b1;
    clr_due_d = clr_due_q;
    if (clr_take) clr_due_d = 1'b0;
    if (clr_wrap) clr_due_d = 1'b1;
  end
`endif

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    ld_idx_d  = ld_idx_q;
    st_idx_d  = st_idx_q;
    lv_d      = lv_q;
    sv_d      = sv_q;
    ls_d      = ls_q;
    ss_d      = ss_q;
    alloc_d   = alloc_q;
    ssid_v_d  = ssid_v_q;
    wr_ld_en  = 1'b0;
    wr_st_en  = 1'b0;
    wr_ld_val = '0;
    wr_st_val = '0;
    merge_min = (ls_q < ss_q) ? ls_q : ss_q;
    clr_take  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef SSIT_PERIODIC_CLEAR_EN
        if (clr_due_q) begin
          clr_take = 1'b1;
          state_d  = S_CLR;
        end else
`endif
        if (viol_req_in) begin
          ld_idx_d = viol_ld_pc_in[IDX_W+1:2];
          st_idx_d = viol_st_pc_in[IDX_W+1:2];
          state_d  = S_RD;
        end
      end
      S_RD: begin
        lv_d    = ssid_v_q[ld_idx_q];
        sv_d    = ssid_v_q[st_idx_q];
        ls_d    = ssid_q[ld_idx_q];
        ss_d    = ssid_q[st_idx_q];
        state_d = S_WR;
      end
      S_WR: begin
        // An aliased ld/st index always has lv == sv, so the 2'b00 arm writes
        // one entry and allocates once; 2'b11 with equal IDs rewrites in place.
        unique case ({lv_q, sv_q})
          2'b00: begin
            wr_ld_en  = 1'b1;
            wr_st_en  = 1'b1;
            wr_ld_val = alloc_q;
            wr_st_val = alloc_q;
            alloc_d   = alloc_q + 1'b1;
          end
          2'b10: begin
            wr_st_en  = 1'b1;
            wr_st_val = ls_q;
          end
          2'b01: begin
            wr_ld_en  = 1'b1;
            wr_ld_val = ss_q;
          end
          default: begin
            wr_ld_en  = 1'b1;
            wr_st_en  = 1'b1;
            wr_ld_val = merge_min;
            wr_st_val = merge_min;
          end
        endcase
        if (wr_ld_en) ssid_v_d[ld_idx_q] = 1'b1;
        if (wr_st_en) ssid_v_d[st_idx_q] = 1'b1;
        state_d = S_IDLE;
      end
`ifdef SSIT_PERIODIC_CLEAR_EN
      S_CLR: begin
        ssid_v_d = '0;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign viol_ack_out = (state_q == S_WR);
  assign busy_out     = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ld_idx_q <= '0;
      st_idx_q <= '0;
      lv_q     <= 1'b0;
      sv_q     <= 1'b0;
      ls_q     <= '0;
      ss_q     <= '0;
      alloc_q  <= '0;
      ssid_v_q <= '0;
      for (int i = 0; i < 4; i++) begin
        lk_ssid_q[i] <= '0;
        lk_v_q[i]    <= 1'b0;
      end
`ifdef SSIT_PERIODIC_CLEAR_EN
      clr_cnt_q <= '0;
      clr_due_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_idx_q <= ld_idx_d;
      st_idx_q <= st_idx_d;
      lv_q     <= lv_d;
      sv_q     <= sv_d;
      ls_q     <= ls_d;
      ss_q     <= ss_d;
      alloc_q  <= alloc_d;
      ssid_v_q <= ssid_v_d;
      for (int i = 0; i < 4; i++) begin
        lk_ssid_q[i] <= lk_ssid_d[i];
        lk_v_q[i]    <= lk_v_d[i];
      end
`ifdef SSIT_PERIODIC_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
      clr_due_q <= clr_due_d;
`endif
    end
  end

  // NOTE: the ID array is not reset; entries are meaningless until their
  // valid bit is set, which keeps this a plain RAM.
  always_ff @(posedge clock) begin
    if (reset_n && wr_ld_en) ssid_q[ld_idx_q] <= wr_ld_val;
    if (reset_n && wr_st_en) ssid_q[st_idx_q] <= wr_st_val;
  end

endmodule

// File: tb/tb_ssit.sv
// ---------------------------------------------------------------------------
// tb_ssit -- directed self-checking bench for ssit.
// IDX_W is widened to 14 so the 0x1000-stride test PCs map to distinct
// entries; PCs 0x10000 apart alias to the same entry.
// ---------------------------------------------------------------------------
module tb_ssit;

  logic        clock;
  logic        reset_n;
  logic [63:0] pc_a [4];
  logic        vl_a [4];
  logic [6:0]  so   [4];
  logic        vo   [4];
  logic        viol_req_in;
  logic [63:0] viol_ld_pc_in, viol_st_pc_in;
  logic        viol_ack_out, busy_out;

  int checks   = 0;
  int failures = 0;

  ssit #(.IDX_W(14), .SSID_W(7), .CLEAR_PERIOD(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc0_in       (pc_a[0]),
    .pc1_in       (pc_a[1]),
    .pc2_in       (pc_a[2]),
    .pc3_in       (pc_a[3]),
    .valid0_in    (vl_a[0]),
    .valid1_in    (vl_a[1]),
    .valid2_in    (vl_a[2]),
    .valid3_in    (vl_a[3]),
    .ssid0_out    (so[0]),
    .ssid1_out    (so[1]),
    .ssid2_out    (so[2]),
    .ssid3_out    (so[3]),
    .ssid_v0_out  (vo[0]),
    .ssid_v1_out  (vo[1]),
    .ssid_v2_out  (vo[2]),
    .ssid_v3_out  (vo[3]),
    .viol_req_in  (viol_req_in),
    .viol_ld_pc_in(viol_ld_pc_in),
    .viol_st_pc_in(viol_st_pc_in),
    .viol_ack_out (viol_ack_out),
    .busy_out     (busy_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      pc_a[i] = '0;
      vl_a[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    viol_req_in = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Look up one PC in the given slot and compare the registered result.
  task automatic expect_pc(input string tag, input int slot, input logic [63:0] pc,
                           input logic v, input logic [6:0] s);
    idle_inputs();
    pc_a[slot] = pc;
    vl_a[slot] = 1'b1;
    tick();
    check({tag, "_v"}, vo[slot], v);
    if (v) check({tag, "_id"}, so[slot], s);
    idle_inputs();
  endtask

  // Raise a violation, wait (bounded) for the ack, then drop req. During the
  // ack cycle the load PC is looked up; v_wr returns that pre-write result.
  task automatic violate(input logic [63:0] ld, input logic [63:0] st,
                         output int lat, output logic v_wr);
    viol_ld_pc_in = ld;
    viol_st_pc_in = st;
    viol_req_in   = 1'b1;
    lat = 0;
    while (!viol_ack_out && lat < 8) begin
      tick();
      lat++;
    end
    if (!viol_ack_out) check("viol_ack_timeout", viol_ack_out, 1'b1);
    viol_req_in = 1'b0;
    pc_a[0] = ld;
    vl_a[0] = 1'b1;
    tick();
    v_wr = vo[0];
    check("ack_pulse", viol_ack_out, 1'b0);
    idle_inputs();
  endtask

  int   lat;
  logic vw;

  initial begin
    viol_ld_pc_in = '0;
    viol_st_pc_in = '0;

    // ---- reset state (checked while reset is still held) ----
    reset_n     = 1'b0;
    viol_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_a[i] = 64'h1000 * (i + 1);
      vl_a[i] = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_id%0d", i), so[i], 7'd0);
      check($sformatf("rst_v%0d", i), vo[i], 1'b0);
    end
    check("rst_ack", viol_ack_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) check($sformatf("empty_v%0d", i), vo[i], 1'b0);
    idle_inputs();

    // ---- first violation on empty table ----
    violate(64'h1000, 64'h2000, lat, vw);
    check("first_ack_latency", lat, 2);
    check("lookup_during_wr_old", vw, 1'b0);
    check("busy_after_ack", busy_out, 1'b0);
    expect_pc("first_ld", 1, 64'h1000, 1'b1, 7'd0);
    expect_pc("first_st", 2, 64'h2000, 1'b1, 7'd0);
    violate(64'h3000, 64'h4000, lat, vw);
    expect_pc("second_ld", 3, 64'h3000, 1'b1, 7'd1);
    expect_pc("second_st", 0, 64'h4000, 1'b1, 7'd1);

`ifdef SSIT_PERIODIC_CLEAR_EN
    // ---- periodic clear (CLEAR_PERIOD = 16) ----
    lat = 0;
    while (!busy_out && lat < 40) begin
      tick();
      lat++;
    end
    check("clr_seen", busy_out, 1'b1);
    // Request raised during CLR is held and served after IDLE.
    violate(64'h5000, 64'h6000, lat, vw);
    check("req_during_clr_latency", lat, 3);
    expect_pc("cleared_entry", 0, 64'h1000, 1'b0, 7'd0);
    expect_pc("post_clr_alloc", 1, 64'h5000, 1'b1, 7'd2);
`else
    // ---- valid gating by slot valid ----
    pc_a[2] = 64'h1000;
    vl_a[2] = 1'b0;
    tick();
    check("slot_valid_gate", vo[2], 1'b0);
    idle_inputs();

    // ---- merge to minimum: 0x1000=5, 0x2000=3 ----
    do_reset();
    violate(64'h3000, 64'h4000, lat, vw);
    violate(64'h5000, 64'h6000, lat, vw);
    violate(64'h7000, 64'h8000, lat, vw);
    violate(64'h2000, 64'h9000, lat, vw);
    violate(64'hA000, 64'hB000, lat, vw);
    violate(64'h1000, 64'hC000, lat, vw);
    expect_pc("pre_min_ld", 0, 64'h1000, 1'b1, 7'd5);
    expect_pc("pre_min_st", 1, 64'h2000, 1'b1, 7'd3);
    violate(64'h1000, 64'h2000, lat, vw);
    expect_pc("min_ld", 2, 64'h1000, 1'b1, 7'd3);
    expect_pc("min_st", 3, 64'h2000, 1'b1, 7'd3);
    expect_pc("min_other_kept", 0, 64'hC000, 1'b1, 7'd5);

    // ---- load-only valid, store-only valid ----
    violate(64'h1000, 64'hD000, lat, vw);
    expect_pc("ld_only_st", 1, 64'hD000, 1'b1, 7'd3);
    violate(64'hE000, 64'h2000, lat, vw);
    expect_pc("st_only_ld", 2, 64'hE000, 1'b1, 7'd3);
    violate(64'hF000, 64'hF004, lat, vw);
    expect_pc("alloc_unchanged", 3, 64'hF004, 1'b1, 7'd6);

    // ---- equal IDs: no change ----
    violate(64'h1000, 64'h2000, lat, vw);
    expect_pc("equal_ld", 0, 64'h1000, 1'b1, 7'd3);

    // ---- aliased indices ----
    violate(64'h10100, 64'h20100, lat, vw);
    expect_pc("alias_alloc", 1, 64'h100, 1'b1, 7'd7);
    violate(64'hF008, 64'hF00C, lat, vw);
    expect_pc("alias_single_inc", 2, 64'hF00C, 1'b1, 7'd8);
    violate(64'h100, 64'h100, lat, vw);
    expect_pc("alias_valid_same", 3, 64'h100, 1'b1, 7'd7);
    violate(64'hF010, 64'hF014, lat, vw);
    expect_pc("alias_no_alloc", 0, 64'hF010, 1'b1, 7'd9);

    // ---- reset mid-operation aborts without ack ----
    viol_ld_pc_in = 64'h1000;
    viol_st_pc_in = 64'h2000;
    viol_req_in   = 1'b1;
    tick();
    check("mid_busy", busy_out, 1'b1);
    reset_n     = 1'b0;
    viol_req_in = 1'b0;
    tick();
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_ack", viol_ack_out, 1'b0);
    reset_n = 1'b1;
    tick();
    check("mid_rst_ack_after", viol_ack_out, 1'b0);

    // ---- allocator wrap after 128 new sets ----
    do_reset();
    for (int i = 0; i < 128; i++) violate(64'(i * 8), 64'(i * 8 + 4), lat, vw);
    expect_pc("wrap_first", 0, 64'h0, 1'b1, 7'd0);
    expect_pc("wrap_mid", 1, 64'(64 * 8 + 4), 1'b1, 7'd64);
    expect_pc("wrap_last", 2, 64'(127 * 8), 1'b1, 7'd127);
    violate(64'h8000, 64'h8004, lat, vw);
    expect_pc("wrap_129th", 3, 64'h8004, 1'b1, 7'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
